// File: rtl/ni_packetizer_if.sv
// Core-side request/payload handshake plus router-side flit and credit signals
// of the network-interface packetizer.
interface ni_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [3:0]            pkt_dst;
  logic [2:0]            pkt_len;
  logic                  pl_valid;
  logic                  pl_ready;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  flit_valid;
  logic [2:0]            flit_id;
  logic [3:0]            flit_dst;
  logic [DATA_WIDTH-1:0] flit_data;
  logic                  credit_in;
  logic                  busy;

  // core / router environment that drives the packetizer
  modport master (
    output pkt_valid, pkt_dst, pkt_len, pl_valid, pl_data, credit_in,
    input  pkt_ready, pl_ready, flit_valid, flit_id, flit_dst, flit_data, busy
  );

  // packetizer itself
  modport slave (
    input  pkt_valid, pkt_dst, pkt_len, pl_valid, pl_data, credit_in,
    output pkt_ready, pl_ready, flit_valid, flit_id, flit_dst, flit_data, busy
  );
endinterface

// File: rtl/ni_packetizer.sv
// Network-interface transmitter: serialises packet requests into
// HEADER / PAYLOAD / TAIL flits, gated by a credit counter mirroring the router FIFO.
module ni_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 7,
  parameter int CREDITS    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     cur_addr,
  ni_packetizer_if.slave nif
);
  localparam int              CW           = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]   CRED_MAX     = CW'(CREDITS);
  localparam logic [2:0]      FLIT_HEADER  = 3'b001;
  localparam logic [2:0]      FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0]      FLIT_TAIL    = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [3:0]            dst_r;
  logic [2:0]            len_r;
  logic [2:0]            len_in_s;
  logic [2:0]            wc_r;
  logic [2:0]            wc_s;
  logic [CW-1:0]         credits_r;
  logic                  has_credit_s;
  logic                  accept_s;
  logic                  pkt_ready_s;
  logic                  pl_ready_s;
  logic                  emit_s;
  logic [2:0]            emit_id_s;
  logic [DATA_WIDTH-1:0] emit_data_s;
  logic                  flit_valid_r;
  logic [2:0]            flit_id_r;
  logic [3:0]            flit_dst_r;
  logic [DATA_WIDTH-1:0] flit_data_r;

  // Next-state, handshake and flit-emission decode
  always_comb begin
    state_s      = state_r;
    wc_s         = wc_r;
    accept_s     = 1'b0;
    pkt_ready_s  = 1'b0;
    pl_ready_s   = 1'b0;
    emit_s       = 1'b0;
    emit_id_s    = FLIT_PAYLOAD;
    emit_data_s  = '0;
    has_credit_s = (credits_r != '0);
    // Widen before comparing so the clamp stays meaningful for any MAX_LEN
    if ({1'b0, nif.pkt_len} > 4'(MAX_LEN)) begin
      len_in_s = 3'(MAX_LEN);
    end else begin
      len_in_s = nif.pkt_len;
    end
    case (state_r)
      IDLE: begin
        pkt_ready_s = 1'b1;
        if (nif.pkt_valid) begin
          accept_s = 1'b1;
          wc_s     = 3'd0;
          state_s  = HEAD;
        end else begin
          state_s  = IDLE;
        end
      end
      HEAD: begin
        if (has_credit_s) begin
          emit_s            = 1'b1;
          emit_id_s         = FLIT_HEADER;
          emit_data_s[3:0]  = dst_r;
          emit_data_s[7:4]  = cur_addr;
          emit_data_s[10:8] = len_r;
          state_s           = BODY;
        end else begin
          state_s           = HEAD;
        end
      end
      BODY: begin
        if (len_r == 3'd0) begin
          // Empty packet: a lone TAIL closes it without consuming payload
          if (has_credit_s) begin
            emit_s    = 1'b1;
            emit_id_s = FLIT_TAIL;
            state_s   = IDLE;
          end else begin
            state_s   = BODY;
          end
        end else begin
          pl_ready_s = has_credit_s;
          if (nif.pl_valid && has_credit_s) begin
            emit_s      = 1'b1;
            emit_data_s = nif.pl_data;
            wc_s        = wc_r + 3'd1;
            if (wc_r == (len_r - 3'd1)) begin
              emit_id_s = FLIT_TAIL;
              state_s   = IDLE;
            end else begin
              emit_id_s = FLIT_PAYLOAD;
              state_s   = BODY;
            end
          end else begin
            state_s = BODY;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, packet descriptor and word counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      wc_r    <= 3'd0;
      dst_r   <= 4'd0;
      len_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      wc_r    <= wc_s;
      if (accept_s) begin
        dst_r <= nif.pkt_dst;
        len_r <= len_in_s;
      end else begin
        dst_r <= dst_r;
        len_r <= len_r;
      end
    end
  end

  // Credit counter: a send and a returned credit in one cycle cancel out
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits_r <= CRED_MAX;
    end else if (emit_s && !nif.credit_in) begin
      credits_r <= credits_r - CW'(1);
    end else if (!emit_s && nif.credit_in && (credits_r != CRED_MAX)) begin
      credits_r <= credits_r + CW'(1);
    end else begin
      credits_r <= credits_r;
    end
  end

  // Registered flit outputs; fields hold their value between flits
  always_ff @(posedge clk) begin
    if (!rst) begin
      flit_valid_r <= 1'b0;
      flit_id_r    <= 3'd0;
      flit_dst_r   <= 4'd0;
      flit_data_r  <= '0;
    end else begin
      flit_valid_r <= emit_s;
      if (emit_s) begin
        flit_id_r   <= emit_id_s;
        flit_dst_r  <= dst_r;
        flit_data_r <= emit_data_s;
      end else begin
        flit_id_r   <= flit_id_r;
        flit_dst_r  <= flit_dst_r;
        flit_data_r <= flit_data_r;
      end
    end
  end

  assign nif.pkt_ready  = pkt_ready_s;
  assign nif.pl_ready   = pl_ready_s;
  assign nif.flit_valid = flit_valid_r;
  assign nif.flit_id    = flit_id_r;
  assign nif.flit_dst   = flit_dst_r;
  assign nif.flit_data  = flit_data_r;
  assign nif.busy       = (state_r != IDLE);

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: directed scenarios plus randomized
// packets, checked against a flit-queue and credit-balance reference model.
`timescale 1ns/1ps
module tb_ni_packetizer;
  localparam int         DW         = 32;
  localparam int         ML         = 7;
  localparam int         CR         = 4;
  localparam logic [2:0] ID_HEADER  = 3'b001;
  localparam logic [2:0] ID_PAYLOAD = 3'b010;
  localparam logic [2:0] ID_TAIL    = 3'b100;

  typedef struct packed {
    logic [2:0]    id;
    logic [3:0]    dst;
    logic [DW-1:0] data;
  } flit_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cur_addr;

  ni_packetizer_if #(.DATA_WIDTH(DW)) nif ();

  ni_packetizer #(
    .DATA_WIDTH(DW),
    .MAX_LEN   (ML),
    .CREDITS   (CR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cur_addr(cur_addr),
    .nif     (nif)
  );

  always #5 clk = ~clk;

  int            checks     = 0;
  int            failures   = 0;
  int            avail      = CR;
  int            flits_seen = 0;
  flit_t         exp_q[$];
  logic [DW-1:0] pl_q[$];
  logic [DW-1:0] words[7];
  bit            cin_cap, rst_cap, acc_cap, took_cap;
  bit            rnd_cin = 1'b0;

  // Reference monitor: every flit must match the next expected flit and
  // may only appear while the router has a free slot.
  always @(posedge clk) begin
    flit_t e;
    flit_t g;
    cin_cap = nif.credit_in;
    rst_cap = rst;
    @(negedge clk);
    if (!rst_cap) begin
      avail = CR;
      exp_q.delete();
      checks++;
      assert (nif.flit_valid === 1'b0)
      else begin failures++; $error("FAIL rst_flit_valid got=%b exp=0", nif.flit_valid); end
    end else begin
      if (nif.flit_valid === 1'b1) begin
        flits_seen++;
        checks++;
        assert ((avail > 0) === 1'b1)
        else begin failures++; $error("FAIL flit_without_credit avail=%0d exp>0", avail); end
        checks++;
        assert ((exp_q.size() > 0) === 1'b1)
        else begin failures++; $error("FAIL unexpected_flit got id=%b data=%h", nif.flit_id, nif.flit_data); end
        if (exp_q.size() > 0) begin
          e      = exp_q.pop_front();
          g.id   = nif.flit_id;
          g.dst  = nif.flit_dst;
          g.data = nif.flit_data;
          checks++;
          assert (g === e)
          else begin
            failures++;
            $error("FAIL flit got id=%b dst=%h data=%h exp id=%b dst=%h data=%h",
                   g.id, g.dst, g.data, e.id, e.dst, e.data);
          end
        end
        avail--;
      end
      if (cin_cap && avail < CR) avail++;
    end
  end

  task automatic drive_pl();
    nif.pl_valid = (pl_q.size() > 0);
    nif.pl_data  = (pl_q.size() > 0) ? pl_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    acc_cap  = nif.pkt_valid && nif.pkt_ready && rst;
    took_cap = nif.pl_valid && nif.pl_ready && rst;
    @(negedge clk);
    #1;
    if (took_cap && pl_q.size() > 0) pl_q.delete(0);
    drive_pl();
    if (rnd_cin) nif.credit_in = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_words();
    for (int i = 0; i < 7; i++) words[i] = DW'($urandom());
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin failures++; $error("FAIL %s got=%h exp=%h", tag, got, exp); end
  endtask

  task automatic wait_flits(input int target, input int budget);
    int n = 0;
    while (flits_seen < target && n < budget) begin tick(); n++; end
    chk("wait_flits", DW'(flits_seen >= target), DW'(1));
  endtask

  // Queue the expected flits of one packet, offer the request, and check
  // that the HEADER follows acceptance by one cycle when a credit exists.
  task automatic send_pkt(input logic [3:0] dst, input logic [2:0] len, input int pre);
    flit_t f;
    int    n;
    bit    cr;
    f.id   = ID_HEADER;
    f.dst  = dst;
    f.data = DW'({len, cur_addr, dst});
    exp_q.push_back(f);
    if (len == 3'd0) begin
      f.id   = ID_TAIL;
      f.data = '0;
      exp_q.push_back(f);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        f.id   = (i == int'(len) - 1) ? ID_TAIL : ID_PAYLOAD;
        f.data = words[i];
        exp_q.push_back(f);
      end
    end
    for (int i = 0; i < pre; i++) pl_q.push_back(words[i]);
    drive_pl();
    nif.pkt_dst   = dst;
    nif.pkt_len   = len;
    nif.pkt_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc_cap && n < 50);
    nif.pkt_valid = 1'b0;
    chk("pkt_accept", DW'(acc_cap), DW'(1));
    cr = (avail > 0);
    tick();
    if (cr) chk("header_latency", DW'({nif.flit_valid, nif.flit_id}), DW'({1'b1, ID_HEADER}));
  endtask

  initial begin
    int s;
    int len;
    rst           = 1'b0;
    cur_addr      = 4'h5;
    nif.pkt_valid = 1'b0;
    nif.pkt_dst   = 4'h0;
    nif.pkt_len   = 3'd0;
    nif.pl_valid  = 1'b0;
    nif.pl_data   = '0;
    nif.credit_in = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_flit_id",   DW'(nif.flit_id),   DW'(0));
    chk("rst_flit_dst",  DW'(nif.flit_dst),  DW'(0));
    chk("rst_flit_data", nif.flit_data,      DW'(0));
    chk("rst_busy",      DW'(nif.busy),      DW'(0));
    chk("rst_pkt_ready", DW'(nif.pkt_ready), DW'(1));
    chk("rst_pl_ready",  DW'(nif.pl_ready),  DW'(0));
    rst = 1'b1;
    tick();

    // Basic 3-word packet, flits in consecutive cycles, drains all credits
    words[0] = DW'(32'h11); words[1] = DW'(32'h22); words[2] = DW'(32'h33);
    send_pkt(4'hA, 3'd3, 3);
    chk("t1_header_data", nif.flit_data, DW'(32'h35A));
    chk("t1_header_dst",  DW'(nif.flit_dst), DW'(4'hA));
    repeat (3) begin
      tick();
      chk("t1_consecutive", DW'(nif.flit_valid), DW'(1));
    end
    chk("t1_last_is_tail", DW'(nif.flit_id), DW'(ID_TAIL));
    tick();
    chk("t1_idle_ready", DW'({nif.pkt_ready, nif.busy, nif.flit_valid}), DW'(3'b100));

    // No credits left: HEADER stalls until exactly one credit returns
    fill_words();
    send_pkt(4'($urandom()), 3'd1, 1);
    repeat (4) begin
      tick();
      chk("t2_stall", DW'({nif.flit_valid, nif.busy}), DW'(2'b01));
    end
    nif.credit_in = 1'b1;
    tick();
    nif.credit_in = 1'b0;
    tick();
    chk("t2_header_once", DW'({nif.flit_valid, nif.flit_id}), DW'({1'b1, ID_HEADER}));
    repeat (3) begin
      tick();
      chk("t2_stall_resume", DW'(nif.flit_valid), DW'(0));
    end
    nif.credit_in = 1'b1;
    wait_flits(flits_seen + 1, 20);
    repeat (CR + 2) tick();
    nif.credit_in = 1'b0;

    // Zero-length packet to self: HEADER then empty TAIL, no payload pulled
    s = flits_seen;
    send_pkt(4'h5, 3'd0, 0);
    chk("t3_header_data", nif.flit_data, DW'(32'h055));
    repeat (3) begin
      chk("t3_no_pl_ready", DW'(nif.pl_ready), DW'(0));
      tick();
    end
    chk("t3_two_flits", DW'(flits_seen - s), DW'(2));

    // Credit returned on every flit keeps the count steady across a full packet
    fill_words();
    nif.credit_in = 1'b1;
    s = flits_seen;
    send_pkt(4'($urandom()), 3'd7, 7);
    repeat (7) tick();
    chk("t4_no_stall", DW'(flits_seen - s), DW'(8));
    repeat (3) tick();
    nif.credit_in = 1'b0;
    // Extra credits at full must saturate: exactly CR flits before the stall
    fill_words();
    s = flits_seen;
    send_pkt(4'($urandom()), 3'd7, 7);
    repeat (10) tick();
    chk("t4_saturated", DW'(flits_seen - s), DW'(CR));
    nif.credit_in = 1'b1;
    wait_flits(s + 8, 40);
    repeat (CR + 1) tick();

    // Payload gap mid-packet: no flits in the gap, order kept, TAIL on word 7
    fill_words();
    s = flits_seen;
    send_pkt(4'($urandom()), 3'd7, 2);
    wait_flits(s + 3, 20);
    repeat (3) begin
      tick();
      chk("t5_gap_quiet", DW'(nif.flit_valid), DW'(0));
    end
    for (int i = 2; i < 7; i++) pl_q.push_back(words[i]);
    drive_pl();
    wait_flits(s + 8, 20);
    chk("t5_tail_last", DW'(nif.flit_id), DW'(ID_TAIL));
    repeat (CR + 1) tick();

    // Reset during BODY abandons the packet and restores full credit
    fill_words();
    s = flits_seen;
    send_pkt(4'($urandom()), 3'd5, 5);
    wait_flits(s + 3, 20);
    rst           = 1'b0;
    nif.credit_in = 1'b0;
    pl_q.delete();
    drive_pl();
    tick();
    chk("t6_rst_idle", DW'({nif.flit_valid, nif.pkt_ready, nif.busy}), DW'(3'b010));
    rst = 1'b1;
    fill_words();
    s = flits_seen;
    send_pkt(4'($urandom()), 3'd5, 5);
    repeat (10) tick();
    chk("t6_full_credits", DW'(flits_seen - s), DW'(CR));
    nif.credit_in = 1'b1;
    wait_flits(s + 6, 40);
    repeat (CR + 1) tick();
    nif.credit_in = 1'b0;

    // Randomized packets with random credit returns
    rnd_cin = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fill_words();
      len = int'($urandom_range(0, ML));
      s   = flits_seen;
      send_pkt(4'($urandom()), 3'(len), len);
      wait_flits(s + ((len == 0) ? 2 : len + 1), 300);
    end
    rnd_cin       = 1'b0;
    nif.credit_in = 1'b0;
    repeat (3) tick();
    chk("all_flits_seen", DW'(exp_q.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
